// File: rtl/riscv_pkg.sv
// Shared RV32M definitions used by the iterative multiply/divide unit.
package riscv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } mdu_state_e;

  localparam int unsigned MDU_ITERATIONS = 32;

  function automatic logic is_div_op(mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide: 32 steps of shift-add / restoring shift-subtract on one
// shared 33-bit adder, with a fast path for divide-by-zero and signed overflow.
module mdu_iterative
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic                     flush,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [ADDRESS_WIDTH-1:0] rd_out
);

  localparam int unsigned          CntWidth = $clog2(MDU_ITERATIONS);
  localparam logic [CntWidth-1:0]  CntLast  = CntWidth'(MDU_ITERATIONS - 1);
  localparam logic [DATA_WIDTH-1:0] SignMin = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  mdu_state_e               state_q, state_d;
  mdu_op_e                  op_q, op_d, op_in;
  logic [CntWidth-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0]    result_q, result_d;
  logic [ADDRESS_WIDTH-1:0] rd_q, rd_d, rd_out_q, rd_out_d;
  logic                     neg_q, neg_d;

  // Operand conditioning for a newly accepted instruction.
  logic                  a_signed, b_signed, a_neg, b_neg, start_neg, in_rem;
  logic                  div_zero, div_ovf;
  logic [DATA_WIDTH-1:0] a_mag, b_mag, fast_val;

  always_comb begin
    op_in    = mdu_op_e'(funct3);
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (op_in)
      OpMul, OpMulh, OpDiv, OpRem: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OpMulhsu: a_signed = 1'b1;
      default: ;
    endcase
    a_neg     = a_signed & rs1_data[DATA_WIDTH-1];
    b_neg     = b_signed & rs2_data[DATA_WIDTH-1];
    a_mag     = a_neg ? -rs1_data : rs1_data;
    b_mag     = b_neg ? -rs2_data : rs2_data;
    in_rem    = (op_in == OpRem) || (op_in == OpRemu);
    // Remainder follows the dividend; everything else follows the sign product.
    start_neg = in_rem ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div_op(op_in) && (rs2_data == '0);
    div_ovf   = ((op_in == OpDiv) || (op_in == OpRem)) && (rs1_data == SignMin) &&
                (rs2_data == '1);
    if (div_zero) begin
      fast_val = in_rem ? rs1_data : '1;
    end else begin
      fast_val = in_rem ? '0 : SignMin;
    end
  end

  // Shared 33-bit add/sub and one iteration step.
  logic                    is_div_q, sub;
  logic [DATA_WIDTH:0]     rem_sh, add_a, add_b, sum;
  logic [DATA_WIDTH-1:0]   hi_n, lo_n, quot_rem, div_res;
  logic [2*DATA_WIDTH-1:0] prod, prod_fix;

  always_comb begin
    is_div_q = is_div_op(op_q);
    sub      = is_div_q;
    rem_sh   = {hi_q, lo_q[DATA_WIDTH-1]};
    add_a    = is_div_q ? rem_sh : {1'b0, hi_q};
    add_b    = (is_div_q || lo_q[0]) ? {1'b0, opnd_q} : '0;
    sum      = add_a + (add_b ^ {(DATA_WIDTH + 1){sub}}) + {{DATA_WIDTH{1'b0}}, sub};
    if (is_div_q) begin
      // Commit the trial subtraction only when it did not go negative.
      hi_n = sum[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : sum[DATA_WIDTH-1:0];
      lo_n = {lo_q[DATA_WIDTH-2:0], ~sum[DATA_WIDTH]};
    end else begin
      hi_n = sum[DATA_WIDTH:1];
      lo_n = {sum[0], lo_q[DATA_WIDTH-1:1]};
    end
    prod     = {hi_n, lo_n};
    prod_fix = neg_q ? -prod : prod;
    quot_rem = ((op_q == OpRem) || (op_q == OpRemu)) ? hi_n : lo_n;
    div_res  = neg_q ? -quot_rem : quot_rem;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = op_in;
          neg_d = start_neg;
          rd_d  = rd_addr;
          cnt_d = '0;
          hi_d  = '0;
          if (div_zero || div_ovf) begin
            result_d = fast_val;
            rd_out_d = rd_addr;
            state_d  = StDone;
          end else begin
            lo_d    = is_div_op(op_in) ? a_mag : b_mag;
            opnd_d  = is_div_op(op_in) ? b_mag : a_mag;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + CntWidth'(1);
        if (cnt_q == CntLast) begin
          cnt_d    = '0;
          state_d  = StDone;
          rd_out_d = rd_q;
          if (is_div_q) begin
            result_d = div_res;
          end else if (op_q == OpMul) begin
            result_d = prod_fix[DATA_WIDTH-1:0];
          end else begin
            result_d = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // An aborted op leaves the last completed result visible.
    if (flush) begin
      state_d  = StIdle;
      cnt_d    = '0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomised and directed checks of mdu_iterative against a plain-arithmetic RV32M model.
module tb_mdu_iterative;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp;
  int n_err;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  mdu_iterative #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct3  (funct3),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .rd_addr (rd_addr),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, ua, ub, p;
    longint unsigned up;
    logic            ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the unit idle; that cycle is cycle 0.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                        input int exp_lat);
    int cyc;
    start    = 1'b1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check_eq({tag, "_busy1"}, busy, 1'b1);
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_lat"}, cyc, exp_lat);
    check_eq({tag, "_res"}, result, exp_res);
    check_eq({tag, "_rd"}, rd_out, rd);
    last_res = exp_res;
    last_rd  = rd;
    @(negedge clk);
    check_eq({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int          ndone;
    int          d0_cyc, d1_cyc;
    logic [31:0] d0_res, d1_res;
    logic [4:0]  d0_rd;
    logic [2:0]  f;
    logic [31:0] a, b;

    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    funct3   = 3'd0;
    rs1_data = '0;
    rs2_data = '0;
    rd_addr  = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_out", {busy, done, result, rd_out}, '0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 33);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33);
    run_op("div0", 3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
    run_op("rem0", 3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h0, 1);

    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, 5'($urandom), ref_mdu(f, a, b),
             ref_lat(f, a, b));
    end

    // Second start at cycle 10 must be ignored.
    ndone    = 0;
    d0_cyc   = -1;
    d0_res   = '0;
    d0_rd    = '0;
    start    = 1'b1;
    funct3   = 3'd5;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    rd_addr  = 5'd9;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (d0_cyc < 0) begin
          d0_cyc = c;
          d0_res = result;
          d0_rd  = rd_out;
        end
      end
      start = (c == 10);
      if (c == 10) begin
        funct3   = 3'd0;
        rs1_data = 32'd11;
        rs2_data = 32'd13;
        rd_addr  = 5'd17;
      end
    end
    check_eq("ign_ndone", ndone, 1);
    check_eq("ign_cyc", d0_cyc, 33);
    check_eq("ign_res", d0_res, 32'd333);
    check_eq("ign_rd", d0_rd, 5'd9);
    last_res = 32'd333;
    last_rd  = 5'd9;

    // Flush at cycle 15.
    ndone    = 0;
    start    = 1'b1;
    funct3   = 3'd0;
    rs1_data = 32'd3;
    rs2_data = 32'd5;
    rd_addr  = 5'd21;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
      flush = (c == 15);
      if (c == 16) begin
        check_eq("flush_busy", busy, 1'b0);
        check_eq("flush_hold", {result, rd_out}, {last_res, last_rd});
      end
    end
    check_eq("flush_ndone", ndone, 0);

    // Back-to-back with start held: MULH then DIVU.
    ndone    = 0;
    d0_cyc   = -1;
    d1_cyc   = -1;
    d1_res   = '0;
    start    = 1'b1;
    funct3   = 3'd1;
    rs1_data = 32'hFFFF_FFFE;
    rs2_data = 32'd3;
    rd_addr  = 5'd12;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (d0_cyc < 0) begin
          d0_cyc = c;
          d0_res = result;
        end else begin
          d1_cyc = c;
          d1_res = result;
        end
      end
      funct3   = 3'd5;
      rs1_data = 32'hDEAD_BEEF;
      rs2_data = 32'h10;
      rd_addr  = 5'd13;
      start    = (c <= 34);
    end
    check_eq("b2b_ndone", ndone, 2);
    check_eq("b2b_cyc0", d0_cyc, 33);
    check_eq("b2b_res0", d0_res, 32'hFFFF_FFFF);
    check_eq("b2b_cyc1", d1_cyc, 67);
    check_eq("b2b_res1", d1_res, 32'h0DEA_DBEE);

    // Reset at cycle 20 of a new op.
    ndone    = 0;
    start    = 1'b1;
    funct3   = 3'd7;
    rs1_data = 32'd77;
    rs2_data = 32'd5;
    rd_addr  = 5'd30;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
      reset = (c == 20);
      if (c == 21) check_eq("rst_mid_out", {busy, done, result, rd_out}, '0);
    end
    check_eq("rst_mid_ndone", ndone, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
